// File: rtl/axis_pattern_src.sv
// AXI4-Stream test-frame source: emits R,G,B bytes per pixel in row-major order,
// with tlast on the blue byte of each line's last pixel.
module axis_pattern_src #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned CHECK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        axis_tvalid,
  input  logic        axis_tready,
  output logic [7:0]  axis_tdata,
  output logic        axis_tstrb,
  output logic        axis_tkeep,
  output logic        axis_tlast,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int unsigned XW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sub, sub_nxt, sub_adv;
  logic [XW-1:0] x, x_nxt, x_adv;
  logic [YW-1:0] y, y_nxt, y_adv;
  logic [1:0]    mode_q, mode_nxt;
  logic [23:0]   solid_q, solid_nxt;
  logic          tvalid_nxt, tlast_nxt, busy_nxt;
  logic [7:0]    tdata_nxt;
  logic [15:0]   frame_cnt_nxt;
  logic          hs, line_end, frame_end;

  assign axis_tstrb = 1'b1;
  assign axis_tkeep = 1'b1;

  // Colour byte for one channel of one pixel.
  function automatic logic [7:0] pixel_byte(input logic [1:0] m, input logic [23:0] rgb,
                                            input logic [XW-1:0] px, input logic [YW-1:0] py,
                                            input logic [1:0] s);
    logic [2:0] bar;
    logic       chk;
    logic [7:0] r, g, b;
    bar = 3'(32'(px) / BAR_W);
    chk = 1'((32'(px) >> CHECK_LOG2) ^ (32'(py) >> CHECK_LOG2));
    r = 8'h00;
    g = 8'h00;
    b = 8'h00;
    case (m)
      2'd0: begin
        r = {8{~bar[1]}};
        g = {8{~bar[2]}};
        b = {8{~bar[0]}};
      end
      2'd1: begin
        r = 8'(px);
        g = 8'(px);
        b = 8'(px);
      end
      2'd2: begin
        r = {8{chk}};
        g = {8{chk}};
        b = {8{chk}};
      end
      default: begin
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
      end
    endcase
    case (s)
      2'd0:    return r;
      2'd1:    return g;
      default: return b;
    endcase
  endfunction

  // Next-state, counter advance and output staging.
  always_comb begin
    state_nxt     = state;
    sub_nxt       = sub;
    x_nxt         = x;
    y_nxt         = y;
    mode_nxt      = mode_q;
    solid_nxt     = solid_q;
    tvalid_nxt    = axis_tvalid;
    tdata_nxt     = axis_tdata;
    tlast_nxt     = axis_tlast;
    busy_nxt      = busy;
    frame_cnt_nxt = frame_cnt;

    hs        = axis_tvalid && axis_tready;
    line_end  = (sub == 2'd2) && (x == X_LAST);
    frame_end = line_end && (y == Y_LAST);
    sub_adv   = (sub == 2'd2) ? 2'd0 : sub + 2'd1;
    x_adv     = (sub != 2'd2) ? x : ((x == X_LAST) ? '0 : x + XW'(1));
    y_adv     = !line_end ? y : ((y == Y_LAST) ? '0 : y + YW'(1));

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt  = STREAM;
          mode_nxt   = mode;
          solid_nxt  = solid_rgb;
          sub_nxt    = '0;
          x_nxt      = '0;
          y_nxt      = '0;
          tvalid_nxt = 1'b1;
          busy_nxt   = 1'b1;
          tlast_nxt  = 1'b0;
          tdata_nxt  = pixel_byte(mode, solid_rgb, XW'(0), YW'(0), 2'd0);
        end
      end
      STREAM: begin
        if (hs) begin
          if (frame_end) begin
            frame_cnt_nxt = frame_cnt + 16'd1;
            sub_nxt       = '0;
            x_nxt         = '0;
            y_nxt         = '0;
            tlast_nxt     = 1'b0;
            // Back-to-back frame: new pattern takes effect on the first byte.
            if (en) begin
              mode_nxt  = mode;
              solid_nxt = solid_rgb;
              tdata_nxt = pixel_byte(mode, solid_rgb, XW'(0), YW'(0), 2'd0);
            end else begin
              state_nxt  = IDLE;
              tvalid_nxt = 1'b0;
              busy_nxt   = 1'b0;
              tdata_nxt  = 8'h00;
            end
          end else begin
            sub_nxt   = sub_adv;
            x_nxt     = x_adv;
            y_nxt     = y_adv;
            tdata_nxt = pixel_byte(mode_q, solid_q, x_adv, y_adv, sub_adv);
            tlast_nxt = (sub_adv == 2'd2) && (x_adv == X_LAST);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sub         <= '0;
      x           <= '0;
      y           <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      axis_tvalid <= 1'b0;
      axis_tdata  <= 8'h00;
      axis_tlast  <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      sub         <= sub_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      mode_q      <= mode_nxt;
      solid_q     <= solid_nxt;
      axis_tvalid <= tvalid_nxt;
      axis_tdata  <= tdata_nxt;
      axis_tlast  <= tlast_nxt;
      busy        <= busy_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

endmodule
